// File: rtl/spectrum_pkg.sv
// Shared definitions for the spectrum bar renderer: bin geometry, index width,
// value-to-pixel scaling, the default update prescaler and the peak tracker states.
package spectrum_pkg;

    localparam logic [15:0] PRESCALE_DEFAULT = 16'd1900;

    typedef enum logic {
        PK_HOLD  = 1'b0,
        PK_DECAY = 1'b1
    } peak_state_e;

    function automatic int idx_width(input int num_bins);
        return (num_bins < 2) ? 1 : $clog2(num_bins);
    endfunction

    function automatic int bin_width(input int screen_w, input int num_bins);
        return screen_w / num_bins;
    endfunction

    function automatic logic [31:0] bar_height(input logic [31:0] val, input int val_w,
                                               input int screen_h);
        logic [63:0] prod;
        prod = {32'd0, val} * {32'd0, 32'(screen_h)};
        return 32'(prod >> val_w);
    endfunction

endpackage

// File: rtl/spectrum_bar_renderer_if.sv
// Bus between the pixel/audio front end and the spectrum bar renderer.
interface spectrum_bar_renderer_if
    import spectrum_pkg::*;
#(
    parameter int NUM_BINS = 10,
    parameter int VAL_W    = 12,
    parameter int POS_W    = 10,
    parameter int IDX_W    = idx_width(NUM_BINS)
);
    logic                      sample_tick;
    logic [NUM_BINS*VAL_W-1:0] bins_in;
    logic                      frame_start;
    logic [POS_W-1:0]          posx;
    logic [POS_W-1:0]          posy;
    logic                      cfg_load;
    logic [15:0]               prescaler_in;
    logic [15:0]               prescaler;
    logic                      set_values_flag;
    logic [IDX_W-1:0]          bin_idx;
    logic [VAL_W-1:0]          val_out;
    logic                      bar_on;
    logic                      peak_on;

    modport master (
        output sample_tick, bins_in, frame_start, posx, posy, cfg_load, prescaler_in,
        input  prescaler, set_values_flag, bin_idx, val_out, bar_on, peak_on
    );

    modport slave (
        input  sample_tick, bins_in, frame_start, posx, posy, cfg_load, prescaler_in,
        output prescaler, set_values_flag, bin_idx, val_out, bar_on, peak_on
    );
endinterface

// File: rtl/bin_peak_tracker.sv
// Peak-hold / decay tracker for a single spectrum bin, advanced once per frame.
module bin_peak_tracker
    import spectrum_pkg::*;
#(
    parameter int VAL_W       = 12,
    parameter int HOLD_FRAMES = 30,
    parameter int DECAY_STEP  = 8
) (
    input  logic             vga_clk,
    input  logic             reset,
    input  logic             frame_start,
    input  logic [VAL_W-1:0] snap_new,
    output logic [VAL_W-1:0] peak
);
    localparam int HOLD_W = (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);

    peak_state_e       state_q, state_d;
    logic [VAL_W-1:0]  peak_q, peak_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [VAL_W-1:0]  decayed;

    // Tracker state register
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            state_q <= PK_DECAY;
            peak_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            peak_q  <= peak_d;
            hold_q  <= hold_d;
        end
    end

    // New peak restarts the hold; otherwise count the hold down, then decay toward the snapshot
    always_comb begin
        state_d = state_q;
        peak_d  = peak_q;
        hold_d  = hold_q;
        decayed = '0;
        if (32'(peak_q) >= 32'(DECAY_STEP)) begin
            decayed = peak_q - VAL_W'(DECAY_STEP);
        end
        if (frame_start) begin
            if (snap_new >= peak_q) begin
                peak_d  = snap_new;
                hold_d  = HOLD_W'(HOLD_FRAMES);
                state_d = (HOLD_FRAMES > 0) ? PK_HOLD : PK_DECAY;
            end else begin
                case (state_q)
                    PK_HOLD: begin
                        hold_d = hold_q - HOLD_W'(1);
                        if (hold_q == HOLD_W'(1)) begin
                            state_d = PK_DECAY;
                        end
                    end
                    default: begin
                        peak_d = (decayed > snap_new) ? decayed : snap_new;
                    end
                endcase
            end
        end
    end

    assign peak = peak_q;
endmodule

// File: rtl/spectrum_bar_renderer.sv
// N-bin spectrum bar graph renderer: per-frame bin snapshot, two-stage pixel
// pipeline producing bar/peak flags, and the prescaled power-update strobe.
// Optional peak-hold markers are built when PEAK_HOLD_EN is defined.
module spectrum_bar_renderer
    import spectrum_pkg::*;
#(
    parameter int          NUM_BINS         = 10,
    parameter int          VAL_W            = 12,
    parameter int          POS_W            = 10,
    parameter int          SCREEN_W         = 800,
    parameter int          SCREEN_H         = 600,
    parameter logic [15:0] PRESCALE_DEFAULT = spectrum_pkg::PRESCALE_DEFAULT,
    parameter int          HOLD_FRAMES      = 30,
    parameter int          DECAY_STEP       = 8
) (
    input logic                   vga_clk,
    input logic                   reset,
    spectrum_bar_renderer_if.slave io
);
    localparam int IDX_W = idx_width(NUM_BINS);
    localparam int BIN_W = bin_width(SCREEN_W, NUM_BINS);
    localparam int SPAN  = NUM_BINS * BIN_W;

    logic [15:0]      prescaler_q, prescaler_d;
    logic [15:0]      count_q, count_d;
    logic             flag_q, flag_d;
    logic [VAL_W-1:0] snap_q [NUM_BINS];
    logic [VAL_W-1:0] snap_d [NUM_BINS];
    logic [IDX_W-1:0] idx1_q, idx1_d;
    logic             in_range1_q, in_range1_d;
    logic [POS_W-1:0] posy1_q, posy1_d;
    logic [IDX_W-1:0] bin_idx_q, bin_idx_d;
    logic [VAL_W-1:0] val_out_q, val_out_d;
    logic             bar_on_q, bar_on_d;
    logic             peak_on_q, peak_on_d;
    logic [31:0]      bar_h;
    logic [31:0]      row;

`ifdef PEAK_HOLD_EN
    logic [VAL_W-1:0] peak [NUM_BINS];

    for (genvar k = 0; k < NUM_BINS; k++) begin : g_peak
        bin_peak_tracker #(
            .VAL_W      (VAL_W),
            .HOLD_FRAMES(HOLD_FRAMES),
            .DECAY_STEP (DECAY_STEP)
        ) u_tracker (
            .vga_clk    (vga_clk),
            .reset      (reset),
            .frame_start(io.frame_start),
            .snap_new   (io.bins_in[k*VAL_W +: VAL_W]),
            .peak       (peak[k])
        );
    end
`endif

    // Update strobe: a load restarts the count silently; a tick at the terminal count fires
    always_comb begin
        prescaler_d = prescaler_q;
        count_d     = count_q;
        flag_d      = 1'b0;
        if (io.cfg_load) begin
            prescaler_d = io.prescaler_in;
            count_d     = '0;
        end else if (io.sample_tick) begin
            if (count_q == prescaler_q) begin
                flag_d  = 1'b1;
                count_d = '0;
            end else begin
                count_d = count_q + 16'd1;
            end
        end
    end

    // Prescaler, sample counter and strobe registers
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            prescaler_q <= PRESCALE_DEFAULT;
            count_q     <= '0;
            flag_q      <= 1'b0;
        end else begin
            prescaler_q <= prescaler_d;
            count_q     <= count_d;
            flag_q      <= flag_d;
        end
    end

    // Capture every bin at frame start so bars stay stable for the whole frame
    always_comb begin
        for (int k = 0; k < NUM_BINS; k++) begin
            snap_d[k] = io.frame_start ? io.bins_in[k*VAL_W +: VAL_W] : snap_q[k];
        end
    end

    // Snapshot registers
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_BINS; k++) begin
                snap_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_BINS; k++) begin
                snap_q[k] <= snap_d[k];
            end
        end
    end

    // Stage 1: locate the bin under posx with a comparator chain and flag off-graph pixels
    always_comb begin
        idx1_d = '0;
        for (int k = 1; k < NUM_BINS; k++) begin
            if (32'(io.posx) >= 32'(k * BIN_W)) begin
                idx1_d = IDX_W'(k);
            end
        end
        in_range1_d = (32'(io.posx) < 32'(SPAN)) && (32'(io.posy) < 32'(SCREEN_H));
        posy1_d     = io.posy;
    end

    // Stage 2: scale the bin energy to a bar height and test the pixel row against it
    always_comb begin
        bar_h     = bar_height(32'(snap_q[idx1_q]), VAL_W, SCREEN_H);
        row       = 32'(SCREEN_H - 1) - 32'(posy1_q);
        bin_idx_d = in_range1_q ? idx1_q : '0;
        val_out_d = in_range1_q ? snap_q[idx1_q] : '0;
        bar_on_d  = in_range1_q && (row < bar_h);
`ifdef PEAK_HOLD_EN
        peak_on_d = in_range1_q && (row == bar_height(32'(peak[idx1_q]), VAL_W, SCREEN_H));
`else
        peak_on_d = 1'b0;
`endif
    end

    // Pixel pipeline registers
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            idx1_q      <= '0;
            in_range1_q <= 1'b0;
            posy1_q     <= '0;
            bin_idx_q   <= '0;
            val_out_q   <= '0;
            bar_on_q    <= 1'b0;
            peak_on_q   <= 1'b0;
        end else begin
            idx1_q      <= idx1_d;
            in_range1_q <= in_range1_d;
            posy1_q     <= posy1_d;
            bin_idx_q   <= bin_idx_d;
            val_out_q   <= val_out_d;
            bar_on_q    <= bar_on_d;
            peak_on_q   <= peak_on_d;
        end
    end

    assign io.prescaler       = prescaler_q;
    assign io.set_values_flag = flag_q;
    assign io.bin_idx         = bin_idx_q;
    assign io.val_out         = val_out_q;
    assign io.bar_on          = bar_on_q;
    assign io.peak_on         = peak_on_q;
endmodule

// File: tb/tb_spectrum_bar_renderer.sv
// Scoreboard bench for spectrum_bar_renderer: stimulus queues expected outputs
// tagged with the cycle they are due; a monitor compares them on the falling edge.
module tb_spectrum_bar_renderer;
   localparam int NUM_BINS = 10;
   localparam int VAL_W    = 12;
   localparam int POS_W    = 10;
   localparam int IDX_W    = 4;
`ifdef PEAK_HOLD_EN
   localparam bit PK = 1'b1;
`else
   localparam bit PK = 1'b0;
`endif

   typedef enum int {K_FLAG, K_PRESC, K_IDX, K_VAL, K_BAR, K_PEAK} kind_e;
   typedef struct {
      int    cyc;
      string name;
      kind_e kind;
      int    expv;
   } exp_t;

   exp_t sb[$];
   logic vga_clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   checkCount = 0;
   int   passCount = 0;

   spectrum_bar_renderer_if #(
      .NUM_BINS(NUM_BINS), .VAL_W(VAL_W), .POS_W(POS_W), .IDX_W(IDX_W)
   ) pix_bus ();

   spectrum_bar_renderer #(
      .NUM_BINS(NUM_BINS), .VAL_W(VAL_W), .POS_W(POS_W),
      .SCREEN_W(800), .SCREEN_H(600), .PRESCALE_DEFAULT(16'd1900),
      .HOLD_FRAMES(30), .DECAY_STEP(8)
   ) dut (
      .vga_clk(vga_clk),
      .reset  (reset),
      .io     (pix_bus)
   );

   // Free-running pixel clock
   always #5 vga_clk = ~vga_clk;

   // Cycle index used to time-stamp expectations
   always @(posedge vga_clk) cyc <= cyc + 1;

   function automatic logic [31:0] actual(input kind_e k);
      case (k)
         K_FLAG:  return 32'(pix_bus.set_values_flag);
         K_PRESC: return 32'(pix_bus.prescaler);
         K_IDX:   return 32'(pix_bus.bin_idx);
         K_VAL:   return 32'(pix_bus.val_out);
         K_BAR:   return 32'(pix_bus.bar_on);
         default: return 32'(pix_bus.peak_on);
      endcase
   endfunction

   // Monitor: on each falling edge compare every expectation due now
   initial begin : monitor
      logic [31:0] act;
      forever begin
         @(negedge vga_clk);
         for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
               checkCount++;
               act = actual(sb[i].kind);
               if (sb[i].cyc == cyc && act === 32'(sb[i].expv)) begin
                  passCount++;
               end else begin
                  $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)",
                           sb[i].name, act, sb[i].expv, cyc);
               end
               sb.delete(i);
            end
         end
      end
   end

   task automatic applyStimulus(input bit tick, input bit fstart, input bit load,
                                input int pin, input int px, input int py);
      @(negedge vga_clk);
      pix_bus.sample_tick  = tick;
      pix_bus.frame_start  = fstart;
      pix_bus.cfg_load     = load;
      pix_bus.prescaler_in = 16'(pin);
      pix_bus.posx         = POS_W'(px);
      pix_bus.posy         = POS_W'(py);
   endtask

   task automatic checkOutput(input string name, input kind_e kind, input int lat,
                              input int expv);
      exp_t e;
      e.cyc  = cyc + lat;
      e.name = name;
      e.kind = kind;
      e.expv = expv;
      sb.push_back(e);
   endtask

   task automatic setBin(input int k, input int v);
      pix_bus.bins_in[k*VAL_W +: VAL_W] = VAL_W'(v);
   endtask

   task automatic frame();
      applyStimulus(0, 1, 0, 0, 0, 0);
   endtask

   task automatic pixel(input string name, input int px, input int py, input int idx,
                        input int val, input bit bar, input bit pk);
      applyStimulus(0, 0, 0, 0, px, py);
      checkOutput({name, ".idx"}, K_IDX, 2, idx);
      checkOutput({name, ".val"}, K_VAL, 2, val);
      checkOutput({name, ".bar"}, K_BAR, 2, int'(bar));
      checkOutput({name, ".peak"}, K_PEAK, 2, int'(pk));
   endtask

   // Main stimulus sequence following the test plan
   initial begin : stimulus
      reset = 1'b1;
      pix_bus.sample_tick  = 1'b0;
      pix_bus.frame_start  = 1'b0;
      pix_bus.cfg_load     = 1'b0;
      pix_bus.prescaler_in = '0;
      pix_bus.bins_in      = '0;
      pix_bus.posx         = '0;
      pix_bus.posy         = '0;

      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("rst.flag", K_FLAG, 1, 0);
      checkOutput("rst.presc", K_PRESC, 1, 1900);
      checkOutput("rst.idx", K_IDX, 1, 0);
      checkOutput("rst.val", K_VAL, 1, 0);
      checkOutput("rst.bar", K_BAR, 1, 0);
      checkOutput("rst.peak", K_PEAK, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      reset = 1'b0;

      applyStimulus(0, 0, 1, 4, 0, 0);
      checkOutput("load4.flag", K_FLAG, 1, 0);
      checkOutput("load4.presc", K_PRESC, 1, 4);
      for (int i = 1; i <= 17; i++) begin
         applyStimulus(1, 0, 0, 0, 0, 0);
         checkOutput($sformatf("tick%0d.flag", i), K_FLAG, 1, (i % 5 == 0) ? 1 : 0);
      end
      applyStimulus(1, 0, 1, 0, 0, 0);
      checkOutput("reload0.flag", K_FLAG, 1, 0);
      checkOutput("reload0.presc", K_PRESC, 1, 0);
      for (int i = 1; i <= 3; i++) begin
         applyStimulus(1, 0, 0, 0, 0, 0);
         checkOutput($sformatf("p0tick%0d.flag", i), K_FLAG, 1, 1);
      end
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("idle.flag", K_FLAG, 1, 0);

      setBin(0, 4095);
      setBin(1, 2048);
      setBin(9, 1000);
      frame();
      pixel("f0.in_bar", 85, 300, 1, 2048, 1'b1, 1'b0);
      pixel("f0.bar_top", 85, 299, 1, 2048, 1'b0, PK);
      pixel("f0.last_bin", 799, 300, 9, 1000, 1'b0, 1'b0);
      pixel("f0.last_low", 799, 500, 9, 1000, 1'b1, 1'b0);
      pixel("f0.out_x", 800, 300, 0, 0, 1'b0, 1'b0);
      pixel("f0.top_row", 0, 0, 0, 4095, 1'b0, PK);
      pixel("f0.row598", 0, 1, 0, 4095, 1'b1, 1'b0);
      pixel("f0.out_y", 85, 600, 0, 0, 1'b0, 1'b0);

      setBin(1, 100);
      pixel("midframe", 85, 300, 1, 2048, 1'b1, 1'b0);

      setBin(0, 0);
      frame();
      pixel("f1.bin1", 85, 300, 1, 100, 1'b0, 1'b0);
      pixel("f1.bin1_low", 85, 590, 1, 100, 1'b1, 1'b0);

      for (int f = 2; f <= 30; f++) begin
         frame();
      end
      pixel("hold_end", 0, 0, 0, 0, 1'b0, PK);

      frame();
      pixel("decay1.old", 0, 0, 0, 0, 1'b0, 1'b0);
      pixel("decay1.new", 0, 1, 0, 0, 1'b0, PK);
      frame();
      pixel("decay2.old", 0, 1, 0, 0, 1'b0, 1'b0);
      pixel("decay2.new", 0, 2, 0, 0, 1'b0, PK);

      pix_bus.bins_in = '0;
      setBin(2, 4000);
      applyStimulus(1, 1, 1, 7, 165, 300);
      checkOutput("coinc.flag", K_FLAG, 1, 0);
      checkOutput("coinc.presc", K_PRESC, 1, 7);
      checkOutput("coinc.idx", K_IDX, 2, 2);
      checkOutput("coinc.val", K_VAL, 2, 4000);
      checkOutput("coinc.bar", K_BAR, 2, 1);
      checkOutput("coinc.peak", K_PEAK, 2, 0);
      applyStimulus(0, 0, 0, 0, 165, 300);
      applyStimulus(0, 0, 0, 0, 165, 300);

      #2 reset = 1'b1;
      #1;
      checkCount += 6;
      if (pix_bus.prescaler === 16'd1900) passCount++;
      else $display("[TB] FAIL arst.now.presc: got %0d, expected 1900", pix_bus.prescaler);
      if (pix_bus.set_values_flag === 1'b0) passCount++;
      else $display("[TB] FAIL arst.now.flag: got %0b, expected 0", pix_bus.set_values_flag);
      if (pix_bus.bin_idx === '0) passCount++;
      else $display("[TB] FAIL arst.now.idx: got %0d, expected 0", pix_bus.bin_idx);
      if (pix_bus.val_out === '0) passCount++;
      else $display("[TB] FAIL arst.now.val: got %0d, expected 0", pix_bus.val_out);
      if (pix_bus.bar_on === 1'b0) passCount++;
      else $display("[TB] FAIL arst.now.bar: got %0b, expected 0", pix_bus.bar_on);
      if (pix_bus.peak_on === 1'b0) passCount++;
      else $display("[TB] FAIL arst.now.peak: got %0b, expected 0", pix_bus.peak_on);
      checkOutput("arst.flag", K_FLAG, 1, 0);
      checkOutput("arst.presc", K_PRESC, 1, 1900);
      checkOutput("arst.idx", K_IDX, 1, 0);
      checkOutput("arst.val", K_VAL, 1, 0);
      checkOutput("arst.bar", K_BAR, 1, 0);
      checkOutput("arst.peak", K_PEAK, 1, 0);
      applyStimulus(0, 0, 0, 0, 165, 300);
      reset = 1'b0;
      pixel("post_rst", 165, 300, 2, 0, 1'b0, 1'b0);

      repeat (4) @(negedge vga_clk);
      foreach (sb[i]) begin
         checkCount++;
         $display("[TB] FAIL %s: never compared, expected %0d", sb[i].name, sb[i].expv);
      end
      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end
endmodule

// File: doc/spectrum_bar_renderer.md
Name: spectrum_bar_renderer

Overview:
Parametrised successor to the 10-band display mux: renders an N-bin spectrum bar graph straight to pixel-level bar/peak flags for the VGA pixel path.
- Snapshots all bin energies once per frame so bars do not tear mid-frame.
- Scales each energy to a bar height and compares it against the current pixel.
- Generates the periodic power-update strobe for the band-power calculator, with a runtime-loadable prescaler.

Parameters:
NUM_BINS, 10, number of frequency bands (2..32)
VAL_W, 12, bit width of each bin energy
POS_W, 10, bit width of posx/posy
SCREEN_W, 800, visible width in pixels
SCREEN_H, 600, visible height in pixels
PRESCALE_DEFAULT, 1900, reset value of prescaler (sample ticks per update, minus 1)
HOLD_FRAMES, 30, frames a new peak is held before decaying
DECAY_STEP, 8, peak decrement per frame after hold expires

Ports:
vga_clk  in  1  pixel clock, sole clock
reset  in  1  asynchronous, active-high reset
sample_tick  in  1  one-cycle strobe per audio sample, already synchronous to vga_clk
bins_in  in  NUM_BINS*VAL_W  packed bin energies; bin k at bits [k*VAL_W +: VAL_W]
frame_start  in  1  one-cycle strobe at start of vertical blanking
posx  in  POS_W  current pixel column
posy  in  POS_W  current pixel row, 0 = top
cfg_load  in  1  load prescaler_in
prescaler_in  in  16  new prescaler value
prescaler  out  16  active prescaler
set_values_flag  out  1  one-cycle update strobe to the power calculator
bin_idx  out  $clog2(NUM_BINS)  bin under current pixel
val_out  out  VAL_W  snapshot energy of bin_idx
bar_on  out  1  pixel lies inside the bar
peak_on  out  1  pixel lies on the peak-marker row

Behaviour:
Reset:
- All outputs are 0 except prescaler = PRESCALE_DEFAULT.
- Sample counter, snapshots, peaks and hold counters are cleared.
- Reset is honoured mid-frame; snapshots stay 0 until the next frame_start.

Prescaler and update strobe:
- cfg_load has priority: prescaler <= prescaler_in, counter <= 0, no strobe that cycle.
- Otherwise, on sample_tick with counter == prescaler: set_values_flag = 1 on the next cycle, counter <= 0.
- Otherwise, on sample_tick: counter increments.
- The strobe lasts exactly one cycle and fires every prescaler+1 ticks.
- prescaler = 0 gives a strobe on every tick.

Snapshot:
- On frame_start, every snap[k] <= bins_in slice k in the same edge.
- Snapshots are static for the rest of the frame.
- frame_start and set_values_flag are independent and may coincide.

Pixel pipeline (latency 2 cycles from posx/posy to bin_idx/val_out/bar_on/peak_on; fully pipelined, one pixel per cycle):
- Constant BIN_W = SCREEN_W / NUM_BINS.
- S1 registers bin index k = the largest k with posx >= k*BIN_W (comparator chain), plus in_range = (posx < NUM_BINS*BIN_W) and posy.
- S2 computes bar_h = (snap[k] * SCREEN_H) >> VAL_W (unsigned, full-width product) and row = SCREEN_H-1-posy.
- bar_on = in_range && row < bar_h.
- Out of range (posx >= NUM_BINS*BIN_W, or posy >= SCREEN_H): bin_idx = 0, val_out = 0, bar_on = 0, peak_on = 0.

Optional Feature:
PEAK_HOLD_EN
- Defined: per-bin peak[k] and hold[k] are updated on frame_start, after the new snapshot is compared:
  - If snap >= peak: peak <= snap, hold <= HOLD_FRAMES.
  - Else if hold > 0: hold decrements.
  - Else: peak <= max(peak - DECAY_STEP, snap), saturating, never below snap and never below 0.
  - peak_on = in_range && row == (peak[k]*SCREEN_H)>>VAL_W, computed in S2 with the same latency.
- Undefined: no peak or hold registers are built; peak_on is tied 0.

Decomposition:
- Package spectrum_pkg holds:
  - BIN_W and the index-width function
  - the bar-height scaling function (value to pixels)
  - PRESCALE_DEFAULT
- One sub-module, bin_peak_tracker: one instance per bin via generate, holding the peak/hold state machine. It is present only under PEAK_HOLD_EN.
- Prescaler counter, snapshot and pixel pipeline stay in the top module.

Test Plan:
- Reset, then prescaler=4 via cfg_load, continuous sample_tick: set_values_flag pulses one cycle on ticks 5, 10, 15. Reload to 0 mid-count: counter restarts and a strobe follows every tick after that.
- bins_in bin1=2048, frame_start, posx=85, posy=300: two cycles later bin_idx=1, val_out=2048, bar_on=1. With posy=299: bar_on=0 (bar_h=300).
- Change bins_in mid-frame without frame_start: val_out unchanged until the next frame_start.
- posx=800 (out of range) and posx=799: first gives bin_idx=0, val_out=0, bar_on=0; second gives bin_idx=9.
- PEAK_HOLD_EN: bin0 = 4095 for one frame, then 0:
  - peak holds at 4095 for 30 frames, then drops 8 per frame (4087, 4079, ...).
  - peak_on is asserted at row 599 during the hold.
- sample_tick, frame_start and cfg_load in the same cycle, then async reset asserted mid-frame: cfg_load wins with no strobe and the snapshot latches; reset clears all outputs immediately, with prescaler = 1900.
